// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: tracks X/M/W destinations, produces
// registered forwarding selects, load-use stalls and redirect squashes.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             valid_D,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic [4:0]       rd_D,
  input  logic             we_D,
  input  logic             load_D,
  input  logic             redirect_X,
  output logic [1:0]       rs1_sel,
  output logic [1:0]       rs2_sel,
  output logic             stall_FD,
  output logic             bubble_X,
  output logic             kill_D,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] redirects
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       load;
  } stage_t;

  stage_t x_reg, m_reg, w_reg;
  logic [1:0][1:0] sel_reg;
  logic [1:0][1:0] sel_next;
  logic [CNT_W-1:0] lu_cnt_reg;
  logic [CNT_W-1:0] redir_cnt_reg;

  logic [1:0][4:0] rs_d;
  logic [1:0]      used_d;
  logic [1:0]      lu_src;
  logic            lu;

  function automatic logic hit(input stage_t s, input logic [4:0] r);
    return s.valid & s.we & (s.rd == r) & (r != 5'd0);
  endfunction

  assign rs_d   = {rs2_D, rs1_D};
  assign used_d = {rs2_used_D, rs1_used_D};

  // Youngest producer wins: the X-stage instruction will sit in M when the
  // reader reaches X, so it takes priority over the M-stage one.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign sel_next[gi] = (!used_d[gi] || rs_d[gi] == 5'd0) ? 2'd0 :
                          hit(x_reg, rs_d[gi])              ? 2'd1 :
                          hit(m_reg, rs_d[gi])              ? 2'd2 : 2'd0;
    assign lu_src[gi]   = used_d[gi] & hit(x_reg, rs_d[gi]);
  end

  assign lu = valid_D & x_reg.load & (|lu_src);

  always_comb begin
    stall_FD = 1'b0;
    bubble_X = 1'b0;
    kill_D   = 1'b0;
    if (freeze) begin
      stall_FD = 1'b1;
    end else if (redirect_X) begin
      kill_D   = 1'b1;
      bubble_X = 1'b1;
    end else if (lu) begin
      stall_FD = 1'b1;
      bubble_X = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_reg         <= '0;
      m_reg         <= '0;
      w_reg         <= '0;
      sel_reg       <= '0;
      lu_cnt_reg    <= '0;
      redir_cnt_reg <= '0;
    end else if (!freeze) begin
      w_reg <= m_reg;
      m_reg <= x_reg;
      if (bubble_X) begin
        x_reg.valid <= 1'b0;
        sel_reg     <= '0;
      end else begin
        x_reg   <= '{valid: valid_D, rd: rd_D, we: we_D, load: load_D};
        sel_reg <= sel_next;
      end
      if (lu && !redirect_X && lu_cnt_reg != '1)
        lu_cnt_reg <= lu_cnt_reg + 1'b1;
      if (redirect_X && redir_cnt_reg != '1)
        redir_cnt_reg <= redir_cnt_reg + 1'b1;
    end
  end

  // W is tracked to complete the pipeline picture; the write-through register
  // file covers W-to-D, so nothing here consumes it.
  logic unused_w;
  assign unused_w = ^w_reg;

  assign rs1_sel   = sel_reg[0];
  assign rs2_sel   = sel_reg[1];
  assign lu_stalls = lu_cnt_reg;
  assign redirects = redir_cnt_reg;

endmodule
